// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the parametrised serial pattern detector.
// Optional match counter is enabled by defining SEQ_DET_MATCH_CNT_EN.
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HUNT = 2'd2
    } seq_det_state_t;

    // A length of zero, or one longer than the window, selects the full window.
    function automatic int clamp_len(input int len, input int max_len);
        return ((len == 0) || (len > max_len)) ? max_len : len;
    endfunction

endpackage

// File: rtl/seq_det_if.sv
// Signal bundle between a serial source/config master and the detector.
// match_cnt exists only when SEQ_DET_MATCH_CNT_EN is defined.
interface seq_det_if
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8,
    parameter int LEN_W = $clog2(PAT_W + 1)
) ();

    // Handshake: no backpressure. The bit on `in` is consumed on every posedge
    // where en=1 and the detector is in FILL or HUNT; cfg_load takes priority
    // and discards that cycle's bit. `out` is a one-cycle pulse per match.
    logic             en;
    logic             in;
    logic             cfg_load;
    logic [PAT_W-1:0] cfg_pat;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_overlap;
    logic             out;
    logic             armed;
    seq_det_state_t   state;
`ifdef SEQ_DET_MATCH_CNT_EN
    logic [CNT_W-1:0] match_cnt;
`endif

    modport master (
        output en, in, cfg_load, cfg_pat, cfg_len, cfg_overlap,
`ifdef SEQ_DET_MATCH_CNT_EN
        input  match_cnt,
`endif
        input  out, armed, state
    );

    modport slave (
        input  en, in, cfg_load, cfg_pat, cfg_len, cfg_overlap,
`ifdef SEQ_DET_MATCH_CNT_EN
        output match_cnt,
`endif
        output out, armed, state
    );

endinterface

// File: rtl/seq_det_window.sv
// Shift window, saturating fill counter and length-masked compare.
// match_now is combinational and reflects the window after this cycle's shift.
module seq_det_window #(
    parameter int PAT_W = 8,
    parameter int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             shift,
    input  logic             bit_in,
    input  logic             overlap,
    input  logic [LEN_W-1:0] len,
    input  logic [PAT_W-1:0] pat,
    output logic             match_now,
    output logic             full_now
);

    logic [PAT_W-1:0] window_q;
    logic [PAT_W-1:0] window_nxt;
    logic [PAT_W-1:0] mask;
    logic [LEN_W-1:0] fill_q;
    logic [LEN_W-1:0] fill_inc;

    always_comb begin
        window_nxt = (window_q << 1) | PAT_W'(bit_in);
        fill_inc   = (fill_q >= len) ? len : (fill_q + LEN_W'(1));
        mask       = {PAT_W{1'b1}} >> (LEN_W'(PAT_W) - len);
        full_now   = shift && (fill_inc == len);
        match_now  = full_now && (((window_nxt ^ pat) & mask) == '0);
    end

    // Non-overlap restarts the fill count so the next match needs len fresh bits.
    always_ff @(posedge clk) begin
        if (!rst) begin
            window_q <= '0;
            fill_q   <= '0;
        end else if (clear) begin
            window_q <= '0;
            fill_q   <= '0;
        end else if (shift) begin
            window_q <= window_nxt;
            fill_q   <= (match_now && !overlap) ? '0 : fill_inc;
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector: FSM, config registers, match pulse.
// Define SEQ_DET_MATCH_CNT_EN to add a saturating match counter.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8
) (
    input  logic     clk,
    input  logic     rst,
    seq_det_if.slave bus
);

    localparam int LEN_W = $clog2(PAT_W + 1);

    seq_det_state_t   state_q, state_d;
    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic             overlap_q;
    logic             out_q, out_d;
    logic             shift;
    logic             match_now;
    logic             full_now;

    assign shift = bus.en && !bus.cfg_load && ((state_q == FILL) || (state_q == HUNT));

    seq_det_window #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_window (
        .clk       (clk),
        .rst       (rst),
        .clear     (bus.cfg_load),
        .shift     (shift),
        .bit_in    (bus.in),
        .overlap   (overlap_q),
        .len       (len_q),
        .pat       (pat_q),
        .match_now (match_now),
        .full_now  (full_now)
    );

    always_comb begin
        state_d = state_q;
        out_d   = 1'b0;
        if (bus.cfg_load) begin
            state_d = FILL;
        end else if (shift) begin
            out_d = match_now;
            if (match_now && !overlap_q) state_d = FILL;
            else if (full_now)           state_d = HUNT;
            else                         state_d = FILL;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            pat_q     <= '0;
            len_q     <= LEN_W'(PAT_W);
            overlap_q <= 1'b1;
            out_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            if (bus.cfg_load) begin
                pat_q     <= bus.cfg_pat;
                len_q     <= LEN_W'(clamp_len(int'(bus.cfg_len), PAT_W));
                overlap_q <= bus.cfg_overlap;
            end
        end
    end

    assign bus.out   = out_q;
    assign bus.armed = (state_q == HUNT);
    assign bus.state = state_q;

`ifdef SEQ_DET_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Counts on the same edge that raises out, so it tracks the pulses exactly.
    always_ff @(posedge clk) begin
        if (!rst)                          cnt_q <= '0;
        else if (bus.cfg_load)             cnt_q <= '0;
        else if (out_d && (cnt_q != '1))   cnt_q <= cnt_q + CNT_W'(1);
    end

    assign bus.match_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param; the counter scenario runs when
// SEQ_DET_MATCH_CNT_EN is defined.
module tb_seq_detector_param;
    import seq_det_pkg::*;

    localparam int PAT_W = 8;
    localparam int CNT_W = 2;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    seq_det_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

    seq_detector_param #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required end of stimulus");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic drive_bit(input logic b, input logic e);
        bus.in = b;
        bus.en = e;
        @(posedge clk);
        #1;
    endtask

    task automatic load_cfg(input logic [PAT_W-1:0] p, input logic [3:0] l, input logic ovl);
        bus.cfg_load    = 1'b1;
        bus.cfg_pat     = p;
        bus.cfg_len     = l;
        bus.cfg_overlap = ovl;
        bus.en          = 1'b1;
        bus.in          = 1'b1;
        @(posedge clk);
        #1;
        bus.cfg_load = 1'b0;
        checks++;
        if (bus.state !== FILL || bus.out !== 1'b0) begin
            failures++;
            $display("FAIL load_cfg: state=%0d out=%b, required state=%0d out=0", bus.state, bus.out, FILL);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        bus.en = 1'b1;
        bus.in = 1'b1;
        bus.cfg_load = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.cfg_load = 1'b0;
        checks++;
        if (bus.state !== IDLE || bus.out !== 1'b0 || bus.armed !== 1'b0) begin
            failures++;
            $display("FAIL reset: state=%0d out=%b armed=%b, required 0/0/0", bus.state, bus.out, bus.armed);
        end
`ifdef SEQ_DET_MATCH_CNT_EN
        checks++;
        if (bus.match_cnt !== 2'd0) begin
            failures++;
            $display("FAIL reset_cnt: match_cnt=%0d, required 0", bus.match_cnt);
        end
`endif
        rst = 1'b1;
        drive_bit(1'b1, 1'b1);
        checks++;
        if (bus.state !== IDLE || bus.out !== 1'b0) begin
            failures++;
            $display("FAIL idle_hold: state=%0d out=%b, required IDLE/0", bus.state, bus.out);
        end
    endtask

    // Pattern 1011 over 1,0,1,1,0,1,1 in either match mode.
    task automatic run_1011(input logic ovl, input logic [6:0] exp_out, input logic [6:0] exp_arm, input string name);
        logic [6:0] bits;
        bits = 7'b1011011;
        load_cfg(8'b0000_1011, 4'd4, ovl);
        for (int i = 6; i >= 0; i--) begin
            drive_bit(bits[i], 1'b1);
            checks++;
            if (bus.out !== exp_out[i] || bus.armed !== exp_arm[i]) begin
                failures++;
                $display("FAIL %s bit%0d: out=%b armed=%b, required out=%b armed=%b",
                         name, 7 - i, bus.out, bus.armed, exp_out[i], exp_arm[i]);
            end
        end
    endtask

    task automatic test_overlap;
        run_1011(1'b1, 7'b0001001, 7'b0001111, "overlap");
    endtask

    task automatic test_non_overlap;
        run_1011(1'b0, 7'b0001000, 7'b0000000, "non_overlap");
    endtask

    task automatic test_len1;
        logic [3:0] bits;
        bits = 4'b1011;
        load_cfg(8'h01, 4'd1, 1'b1);
        for (int i = 3; i >= 0; i--) begin
            drive_bit(bits[i], 1'b1);
            checks++;
            if (bus.out !== bits[i] || bus.armed !== 1'b1) begin
                failures++;
                $display("FAIL len1 bit%0d: out=%b armed=%b, required out=%b armed=1",
                         4 - i, bus.out, bus.armed, bits[i]);
            end
        end
    endtask

    task automatic test_en_gate;
        int pulses;
        pulses = 0;
        load_cfg(8'b0000_1011, 4'd4, 1'b1);
        drive_bit(1'b1, 1'b1); pulses += int'(bus.out);
        drive_bit(1'b0, 1'b1); pulses += int'(bus.out);
        drive_bit(1'b1, 1'b1); pulses += int'(bus.out);
        for (int i = 0; i < 3; i++) begin
            drive_bit(1'b1, 1'b0);
            checks++;
            if (bus.out !== 1'b0 || bus.state !== FILL) begin
                failures++;
                $display("FAIL en_gate_hold%0d: out=%b state=%0d, required out=0 state=%0d", i, bus.out, bus.state, FILL);
            end
        end
        drive_bit(1'b1, 1'b1); pulses += int'(bus.out);
        checks++;
        if (bus.out !== 1'b1 || pulses != 1) begin
            failures++;
            $display("FAIL en_gate_match: out=%b pulses=%0d, required out=1 pulses=1", bus.out, pulses);
        end
        drive_bit(1'b1, 1'b0);
        checks++;
        if (bus.out !== 1'b0) begin
            failures++;
            $display("FAIL en_gate_drop: out=%b, required 0", bus.out);
        end
    endtask

    task automatic test_reset_mid;
        load_cfg(8'b0000_1011, 4'd4, 1'b1);
        drive_bit(1'b1, 1'b1);
        drive_bit(1'b0, 1'b1);
        drive_bit(1'b1, 1'b1);
        rst = 1'b0;
        drive_bit(1'b1, 1'b1);
        rst = 1'b1;
        checks++;
        if (bus.state !== IDLE || bus.out !== 1'b0 || bus.armed !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: state=%0d out=%b armed=%b, required 0/0/0", bus.state, bus.out, bus.armed);
        end
        drive_bit(1'b1, 1'b1);
        checks++;
        if (bus.state !== IDLE || bus.out !== 1'b0 || bus.armed !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_after: state=%0d out=%b armed=%b, required 0/0/0", bus.state, bus.out, bus.armed);
        end
    endtask

    // cfg_len=0 clamps to the full 8-bit window; only the 8th bit can match.
    task automatic test_len_clamp;
        logic [7:0] bits;
        bits = 8'hA5;
        load_cfg(8'hA5, 4'd0, 1'b1);
        for (int i = 7; i >= 0; i--) begin
            drive_bit(bits[i], 1'b1);
            checks++;
            if (bus.out !== (i == 0)) begin
                failures++;
                $display("FAIL len_clamp bit%0d: out=%b, required %b", 8 - i, bus.out, (i == 0));
            end
        end
    endtask

`ifdef SEQ_DET_MATCH_CNT_EN
    task automatic test_match_cnt;
        logic [1:0] exp_cnt [5];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        load_cfg(8'h01, 4'd1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive_bit(1'b1, 1'b1);
            checks++;
            if (bus.match_cnt !== exp_cnt[i] || bus.out !== 1'b1) begin
                failures++;
                $display("FAIL match_cnt%0d: cnt=%0d out=%b, required cnt=%0d out=1", i, bus.match_cnt, bus.out, exp_cnt[i]);
            end
        end
        load_cfg(8'h01, 4'd1, 1'b1);
        checks++;
        if (bus.match_cnt !== 2'd0) begin
            failures++;
            $display("FAIL match_cnt_clear: cnt=%0d, required 0", bus.match_cnt);
        end
    endtask
`endif

    initial begin
        checks          = 0;
        failures        = 0;
        rst             = 1'b0;
        bus.en          = 1'b0;
        bus.in          = 1'b0;
        bus.cfg_load    = 1'b0;
        bus.cfg_pat     = '0;
        bus.cfg_len     = '0;
        bus.cfg_overlap = 1'b1;
        @(posedge clk);
        #1;
        test_reset;
        test_overlap;
        test_non_overlap;
        test_len1;
        test_en_gate;
        test_reset_mid;
        test_len_clamp;
`ifdef SEQ_DET_MATCH_CNT_EN
        test_match_cnt;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
